// File: rtl/hid_pkg.sv
// hid_pkg: shared constants and the muxed-access record for the HID MMIO port.
//   HID_AW / HID_DW / HID_BE : address width, data width, byte-enable count
//   hid_req_t                : one requester's access fields {we, addr, wdata}
package hid_pkg;

  localparam int HID_AW = 20;
  localparam int HID_DW = 64;
  localparam int HID_BE = 8;

  typedef struct packed {
    logic [HID_BE-1:0] we;
    logic [HID_AW-1:0] addr;
    logic [HID_DW-1:0] wdata;
  } hid_req_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: purely combinational round-robin search.
//   req   : request vector
//   start : index searched first; the search continues upward and wraps
//   gnt   : one-hot winner (zero when nothing requests)
//   any   : at least one request present
module rr_pick #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic          any
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] gnt_dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   gnt_rot;

  // Rotate so that 'start' lands at bit 0, take the lowest set bit,
  // then rotate the one-hot result back into place.
  always_comb begin
    req_dbl = {req, req} >> start;
    rot     = req_dbl[N-1:0];
    gnt_rot = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_rot    = '0;
        gnt_rot[k] = 1'b1;
      end
    end
    gnt_dbl = {gnt_rot, gnt_rot} << start;
    gnt     = gnt_dbl[2*N-1:N];
    any     = |req;
  end

endmodule

// File: rtl/hid_bus_arb.sv
// hid_bus_arb: round-robin arbiter sharing the single HID MMIO port between
// NREQ requesters, with locked bursts capped at MAX_BURST grants while
// someone else waits.
//   clk_i, rst_ni              : clock, async active-low reset
//   req_i, lock_i              : per-requester request / keep-ownership
//   we_i, addr_i, wdata_i      : per-requester access fields (packed)
//   gnt_o                      : one-hot grant, access issued in that cycle
//   rvalid_o, rdata_o          : completion one cycle after grant
//   hid_en/we/addr/wrdata      : HID access, driven in the grant cycle
//   hid_rddata                 : HID read data, valid the cycle after hid_en
//
// mode      | meaning
// ----------+---------------------------------------------------------------
// UNLOCKED  | owner_valid=0: round robin starting after last_owner
// LOCKED    | owner_valid=1: last_owner keeps the bus while it requests
// LOCK_FULL | LOCKED with burst_cnt==MAX_BURST: yields if anyone else waits
module hid_bus_arb
  import hid_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int MAX_BURST = 16,
  parameter int AW        = HID_AW,
  parameter int DW        = HID_DW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   lock_i,
  input  logic [NREQ*8-1:0] we_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   rvalid_o,
  output logic [DW-1:0]     rdata_o,
  output logic              hid_en,
  output logic [7:0]        hid_we,
  output logic [AW-1:0]     hid_addr,
  output logic [DW-1:0]     hid_wrdata,
  input  logic [DW-1:0]     hid_rddata
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  logic [IW-1:0]   last_owner, last_owner_nxt;
  logic            owner_valid, owner_valid_nxt;
  logic [CW-1:0]   burst_cnt, burst_cnt_nxt;
  logic [NREQ-1:0] rvalid_q;

  logic [NREQ-1:0] owner_mask;
  logic            owner_req;
  logic            others_wait;
  logic            burst_full;
  logic            lock_hold;
  logic [IW-1:0]   start;
  logic [NREQ-1:0] rr_gnt;
  logic            rr_any;
  logic [NREQ-1:0] gnt;
  logic            granted;
  logic [IW-1:0]   win_idx;
  hid_req_t        sel;

  // Lock evaluation and round-robin start point.
  always_comb begin
    owner_mask  = NREQ'(1) << last_owner;
    owner_req   = |(req_i & owner_mask);
    others_wait = |(req_i & ~owner_mask);
    burst_full  = (burst_cnt == CW'(MAX_BURST));
    // A full burst only yields when someone else is actually waiting.
    lock_hold   = owner_valid & owner_req & ~(burst_full & others_wait);
    // Search starts after the last owner, so a forced break cannot
    // hand the bus straight back to it.
    start       = (last_owner == IW'(NREQ - 1)) ? '0 : last_owner + IW'(1);
  end

  rr_pick #(.N(NREQ)) u_rr_pick (
    .req   (req_i),
    .start (start),
    .gnt   (rr_gnt),
    .any   (rr_any)
  );

  // Grant is held off while reset is asserted so nothing reaches the HID
  // port during reset.
  always_comb begin
    if (!rst_ni)        gnt = '0;
    else if (lock_hold) gnt = owner_mask;
    else                gnt = rr_any ? rr_gnt : '0;
    granted = |gnt;
    win_idx = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (gnt[r]) win_idx = IW'(r);
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_owner  <= IW'(NREQ - 1);
      owner_valid <= 1'b0;
      burst_cnt   <= '0;
      rvalid_q    <= '0;
    end else begin
      last_owner  <= last_owner_nxt;
      owner_valid <= owner_valid_nxt;
      burst_cnt   <= burst_cnt_nxt;
      rvalid_q    <= gnt;
    end
  end

  // Next-state.
  always_comb begin
    last_owner_nxt  = last_owner;
    owner_valid_nxt = owner_valid;
    burst_cnt_nxt   = burst_cnt;
    if (granted) begin
      last_owner_nxt  = win_idx;
      owner_valid_nxt = |(lock_i & gnt);
      if (owner_valid && (win_idx == last_owner)) begin
        burst_cnt_nxt = burst_full ? burst_cnt : burst_cnt + CW'(1);
      end else begin
        burst_cnt_nxt = CW'(1);
      end
    end else begin
      // No grant means the owner dropped its request: the lock is lost.
      owner_valid_nxt = 1'b0;
      burst_cnt_nxt   = '0;
    end
  end

  // Outputs: bus mux of the winner's fields, zero when idle.
  always_comb begin
    sel = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (gnt[r]) begin
        sel.we    = we_i[r*8 +: 8];
        sel.addr  = addr_i[r*AW +: AW];
        sel.wdata = wdata_i[r*DW +: DW];
      end
    end
    gnt_o      = gnt;
    hid_en     = granted;
    hid_we     = sel.we;
    hid_addr   = sel.addr;
    hid_wrdata = sel.wdata;
    rvalid_o   = rvalid_q;
    rdata_o    = (|rvalid_q) ? hid_rddata : '0;
  end

endmodule

// File: tb/tb_hid_bus_arb.sv
module tb_hid_bus_arb;

  localparam int NREQ = 2;
  localparam int MB   = 4;
  localparam int AW   = 20;
  localparam int DW   = 64;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic [NREQ-1:0]   req_i = '0;
  logic [NREQ-1:0]   lock_i = '0;
  logic [NREQ*8-1:0] we_i;
  logic [NREQ*AW-1:0] addr_i;
  logic [NREQ*DW-1:0] wdata_i;
  logic [NREQ-1:0]   gnt_o;
  logic [NREQ-1:0]   rvalid_o;
  logic [DW-1:0]     rdata_o;
  logic              hid_en;
  logic [7:0]        hid_we;
  logic [AW-1:0]     hid_addr;
  logic [DW-1:0]     hid_wrdata;
  logic [DW-1:0]     hid_rddata = '0;

  logic [7:0]    f_we   [NREQ];
  logic [AW-1:0] f_addr [NREQ];
  logic [DW-1:0] f_wd   [NREQ];

  assign we_i    = {f_we[1], f_we[0]};
  assign addr_i  = {f_addr[1], f_addr[0]};
  assign wdata_i = {f_wd[1], f_wd[0]};

  always #5 clk = ~clk;

  hid_bus_arb #(.NREQ(NREQ), .MAX_BURST(MB), .AW(AW), .DW(DW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .lock_i     (lock_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .hid_en     (hid_en),
    .hid_we     (hid_we),
    .hid_addr   (hid_addr),
    .hid_wrdata (hid_wrdata),
    .hid_rddata (hid_rddata)
  );

  typedef struct {
    logic [1:0]  gnt;
    logic        en;
    logic [7:0]  we;
    logic [19:0] addr;
    logic [63:0] wdata;
    logic [1:0]  rvalid;
    logic [63:0] rdata;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc_no  = 0;
  logic [1:0] prev_gnt = 2'b00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc_no, act, exp);
    end
  endtask

  // Field updates land just after the monitor has sampled, so they never
  // disturb the cycle already being checked.
  task automatic setf(input int r, input logic [7:0] we, input logic [19:0] addr,
                      input logic [63:0] wd);
    @(negedge clk);
    #1;
    f_we[r]   = we;
    f_addr[r] = addr;
    f_wd[r]   = wd;
  endtask

  // One bus cycle: drive inputs just after the edge and queue what the
  // monitor must see in this same cycle.
  task automatic cyc(input logic r, input logic [1:0] req, input logic [1:0] lock,
                     input logic [1:0] eg, input logic [63:0] rd);
    exp_t e;
    @(posedge clk);
    #1;
    rst_ni     = r;
    req_i      = req;
    lock_i     = lock;
    hid_rddata = rd;
    e.gnt   = eg;
    e.en    = |eg;
    e.we    = '0;
    e.addr  = '0;
    e.wdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (eg[k]) begin
        e.we    = f_we[k];
        e.addr  = f_addr[k];
        e.wdata = f_wd[k];
      end
    end
    e.rvalid = r ? prev_gnt : 2'b00;
    e.rdata  = (|e.rvalid) ? rd : 64'h0;
    prev_gnt = r ? eg : 2'b00;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t m;
    forever begin
      @(negedge clk);
      cyc_no++;
      if (sb.size() > 0) begin
        m = sb.pop_front();
        chk("gnt_o",      64'(gnt_o),      64'(m.gnt));
        chk("hid_en",     64'(hid_en),     64'(m.en));
        chk("hid_we",     64'(hid_we),     64'(m.we));
        chk("hid_addr",   64'(hid_addr),   64'(m.addr));
        chk("hid_wrdata", hid_wrdata,      m.wdata);
        chk("rvalid_o",   64'(rvalid_o),   64'(m.rvalid));
        chk("rdata_o",    rdata_o,         m.rdata);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    f_we[0] = 8'h00; f_addr[0] = 20'h00100; f_wd[0] = 64'h0;
    f_we[1] = 8'h0F; f_addr[1] = 20'h00200; f_wd[1] = 64'h1111;

    // reset: requests ignored while rst_ni is low
    cyc(1'b0, 2'b11, 2'b00, 2'b00, 64'h0);
    cyc(1'b0, 2'b00, 2'b00, 2'b00, 64'h0);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 64'h0);

    // plain round robin, requester 0 first
    cyc(1'b1, 2'b11, 2'b00, 2'b01, 64'hA1);
    cyc(1'b1, 2'b11, 2'b00, 2'b10, 64'hA2);
    cyc(1'b1, 2'b11, 2'b00, 2'b01, 64'hA3);
    cyc(1'b1, 2'b11, 2'b00, 2'b10, 64'hA4);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 64'hA5);

    // keyboard status read, data valid only in the rvalid cycle
    setf(0, 8'h00, 20'h30000, 64'h0);
    cyc(1'b1, 2'b01, 2'b00, 2'b01, 64'h0);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 64'h5A5);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 64'h777);

    // requester 1 locked against a waiting requester 0, cap of 4
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'b11, 2'b10, 2'b10, 64'(i + 16));
    cyc(1'b1, 2'b11, 2'b10, 2'b01, 64'h20);
    cyc(1'b1, 2'b11, 2'b10, 2'b10, 64'h21);
    cyc(1'b1, 2'b11, 2'b10, 2'b10, 64'h22);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 64'h23);

    // requester 0 locked alone: counter saturates, owner keeps going
    for (int i = 0; i < 20; i++) cyc(1'b1, 2'b01, 2'b01, 2'b01, 64'(i + 48));
    cyc(1'b1, 2'b11, 2'b01, 2'b10, 64'h70);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 64'h71);

    // owner idles one cycle and loses the lock
    cyc(1'b1, 2'b01, 2'b01, 2'b01, 64'h80);
    cyc(1'b1, 2'b01, 2'b01, 2'b01, 64'h81);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 64'h82);
    cyc(1'b1, 2'b11, 2'b00, 2'b10, 64'h83);

    // owner clears lock_i on a granted access: kept once, then released
    cyc(1'b1, 2'b11, 2'b01, 2'b01, 64'h90);
    cyc(1'b1, 2'b11, 2'b00, 2'b01, 64'h91);
    cyc(1'b1, 2'b11, 2'b00, 2'b10, 64'h92);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 64'h93);

    // full-width write
    setf(0, 8'hFF, 20'h80000, 64'hDEADBEEF_00000001);
    cyc(1'b1, 2'b01, 2'b00, 2'b01, 64'h0);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 64'hB0);

    // reset right after a grant drops the completion; 0 wins afterwards
    cyc(1'b1, 2'b10, 2'b00, 2'b10, 64'hC0);
    cyc(1'b0, 2'b10, 2'b00, 2'b00, 64'hC1);
    cyc(1'b1, 2'b11, 2'b00, 2'b01, 64'hC2);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 64'hC3);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 64'hC4);

    @(negedge clk);
    #2;
    chk("sb_drain", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
